bit_serial_seq: RTL and testbench
=================================

# bit_serial_seq

Instruction sequencer for the 8-bit bit-serial datapath. It latches each 3-bit instruction from program memory and steps the datapath through one instruction at a time: GPR/accumulator shifting, ALU operand selection, carry clearing, switch-bit selection and PC advance. It has a start handshake for switch loads and a run/park control. It drives every `o_con_*` control input of the datapath.

## Interface
- `DATA_W`, default 8: serial word length. Power of two, ≥2. Equals bit cycles per instruction.
- `i_clk`  in  1  clock
- `i_rst`  in  1  synchronous, active-high reset
- `i_instr`  in  3  instruction from program memory. `[2:1]` is the opcode, `[0]` is the rd register select. Valid one cycle after a PC change.
- `i_run`  in  1  level. 1 = fetch and execute. 0 = park in IDLE at the next instruction boundary.
- `i_start`  in  1  operator strobe. Only a 0→1 edge is used.
- `o_con_mux8`  out  $clog2(DATA_W)  switch bit index (current bit number)
- `o_con_mux`  out  1  GPR input select: 1 = switch bit, 0 = ALU sum
- `o_con_muxalu`  out  1  ALU B select: 1 = accumulator bit, 0 = constant 0
- `o_con_gpr_shift`  out  1  rotate GPR[rd] one bit, LSB out
- `o_con_gpr_write`  out  1  when shifting: MSB-in = GPR input. Otherwise the bit shifted out recirculates.
- `o_con_acc_shift`  out  1  rotate accumulator one bit
- `o_con_acc_write`  out  1  when shifting: MSB-in = ALU sum. Otherwise recirculate.
- `o_con_carry_clr`  out  1  force carry register to 0. Dominates carry capture.
- `o_con_pcincr`  out  1  one-cycle PC increment
- `o_rd`  out  1  latched rd, for GPR addressing
- `o_busy`  out  1  state ≠ IDLE
- `o_instr_done`  out  1  one-cycle pulse in ADVANCE

## Operation
Opcodes. All are LSB-first over DATA_W bit cycles.
- `00` LDSW: GPR[rd] ← switches. `mux`=1, `gpr_shift`=1, `gpr_write`=1. Accumulator idle.
- `01` ADD: ACC ← GPR[rd] + ACC. `muxalu`=1, `acc_shift`=1, `acc_write`=1, `gpr_shift`=1, `gpr_write`=0.
- `10` LDA: ACC ← GPR[rd] + 0. `muxalu`=0, `acc_shift`=1, `acc_write`=1, `gpr_shift`=1, `gpr_write`=0.
- `11` ADDG: GPR[rd] ← GPR[rd] + ACC. `mux`=0, `muxalu`=1, `gpr_shift`=1, `gpr_write`=1, `acc_shift`=1, `acc_write`=0.

Operand registers always rotate a full DATA_W bits, so their contents are preserved.

States: IDLE, FETCH, WAIT_START, EXEC, ADVANCE.
- IDLE → FETCH when `i_run`=1.
- FETCH (1 cycle): latch `i_instr` into the IR and `o_rd`. Assert `carry_clr`.
  - Opcode 00 → WAIT_START.
  - Other opcodes → EXEC, with bit counter = 0.
- WAIT_START: hold until a start edge is seen, then → EXEC. `carry_clr` stays asserted.
- EXEC: emit the opcode's controls. `o_con_mux8` = bit counter. The counter increments each cycle. On counter = DATA_W−1, → ADVANCE.
- ADVANCE (1 cycle): `pcincr`=1, `instr_done`=1.
  - → FETCH if `i_run`=1, else → IDLE.

Start edge detection:
- `start_q` is registered `i_start`, reset to 0.
- edge = `i_start & ~start_q`. It is evaluated only in WAIT_START; edges in other states are discarded.
- If `i_start` is held high through reset, that counts as one edge.

All datapath controls are 0 outside the cases listed above. Controls are combinational from state, IR and counter. No output depends combinationally on `i_run` or `i_start`.

## Timing
- Reset (`i_rst`=1 at an edge): next cycle state = IDLE, counter = 0, IR = 0, `start_q` = 0. All outputs 0.
- Reset mid-EXEC: no further shifts and no `pcincr`. The partial datapath result is left as-is.
- Instruction latency, non-LDSW: FETCH 1 + EXEC DATA_W + ADVANCE 1 = 10 cycles at DATA_W=8, back-to-back.
- LDSW latency: 10 cycles + wait. EXEC starts the cycle after the cycle in which the edge is seen.
- `i_run` deasserted mid-instruction: the instruction completes, then the block parks in IDLE after ADVANCE.
- Program memory latency: a PC change in ADVANCE gives a valid `i_instr` in FETCH. Exactly one cycle is assumed.
- PC wrap 7→0 belongs to the PC; the sequencer only pulses.

## Structure
- Package `bit_serial_pkg` holds:
  - `seq_state_t` enum (IDLE, FETCH, WAIT_START, EXEC, ADVANCE)
  - `opcode_t` enum (OP_LDSW=2'b00, OP_ADD, OP_LDA, OP_ADDG)
  - localparam `BIT_CNT_W`
- Single module, no sub-module. The state register, bit counter, IR and `start_q` live in one always_ff block; control decode lives in one always_comb block.

## Test plan
- Reset with `i_run`=0 for 5 cycles → all outputs 0, `o_busy`=0. Set `i_run`=1 → FETCH next cycle with `carry_clr`=1.
- ADD, instr 3'b010 → FETCH, then 8 cycles of `mux8`=0..7 with `acc_shift`=`acc_write`=`gpr_shift`=`muxalu`=1 and `gpr_write`=0, then 1 cycle `pcincr`=`instr_done`=1. Total 10 cycles.
- LDSW, instr 3'b001, `i_start`=0 for 5 cycles then 1 and held → WAIT_START for 5 cycles, EXEC with `o_rd`=1 and `mux`=`gpr_write`=1. The next LDSW stalls until `i_start` goes 0→1 again.
- ADDG, instr 3'b110 → EXEC with `gpr_write`=1, `mux`=0, `acc_shift`=1, `acc_write`=0.
- `i_run` dropped at EXEC bit 3 → bits 4..7 and ADVANCE still occur, then IDLE with no further FETCH.
- `i_rst` at EXEC bit 4 → next cycle all outputs 0, state IDLE, no `pcincr` pulse.

Source files
------------

// File: rtl/bit_serial_pkg.sv
// Shared types for the bit-serial datapath sequencer: FSM states, opcodes
// and the default bit-counter width.
package bit_serial_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int BIT_CNT_W  = $clog2(DATA_W_DEF);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    WAIT_START = 3'd2,
    EXEC       = 3'd3,
    ADVANCE    = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    OP_LDSW = 2'b00,
    OP_ADD  = 2'b01,
    OP_LDA  = 2'b10,
    OP_ADDG = 2'b11
  } opcode_t;

endpackage

// File: rtl/bit_serial_seq.sv
// Instruction sequencer for the bit-serial datapath: fetches one 3-bit
// instruction, then steps DATA_W LSB-first bit cycles of datapath controls.
module bit_serial_seq
  import bit_serial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [2:0]                i_instr,
  input  logic                      i_run,
  input  logic                      i_start,
  output logic [$clog2(DATA_W)-1:0] o_con_mux8,
  output logic                      o_con_mux,
  output logic                      o_con_muxalu,
  output logic                      o_con_gpr_shift,
  output logic                      o_con_gpr_write,
  output logic                      o_con_acc_shift,
  output logic                      o_con_acc_write,
  output logic                      o_con_carry_clr,
  output logic                      o_con_pcincr,
  output logic                      o_rd,
  output logic                      o_busy,
  output logic                      o_instr_done
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ir_q, ir_d;
  logic             start_q;
  logic             start_edge_s;
  opcode_t          op_s;

  assign op_s         = opcode_t'(ir_q[2:1]);
  assign start_edge_s = i_start & ~start_q;
  assign o_rd         = ir_q[0];

  // State, bit counter, instruction register and start-strobe history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ir_q    <= 3'b000;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      start_q <= i_start;
    end
  end

  // Next-state and control decode from state, IR and bit counter only.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ir_d            = ir_q;
    o_con_mux8      = '0;
    o_con_mux       = 1'b0;
    o_con_muxalu    = 1'b0;
    o_con_gpr_shift = 1'b0;
    o_con_gpr_write = 1'b0;
    o_con_acc_shift = 1'b0;
    o_con_acc_write = 1'b0;
    o_con_carry_clr = 1'b0;
    o_con_pcincr    = 1'b0;
    o_instr_done    = 1'b0;
    o_busy          = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (i_run) state_d = FETCH;
        else       state_d = IDLE;
      end
      FETCH: begin
        ir_d            = i_instr;
        cnt_d           = '0;
        o_con_carry_clr = 1'b1;
        if (opcode_t'(i_instr[2:1]) == OP_LDSW) state_d = WAIT_START;
        else                                    state_d = EXEC;
      end
      WAIT_START: begin
        // Carry stays cleared so the switch load starts from a clean ALU.
        o_con_carry_clr = 1'b1;
        cnt_d           = '0;
        if (start_edge_s) state_d = EXEC;
        else              state_d = WAIT_START;
      end
      EXEC: begin
        o_con_mux8 = cnt_q;
        case (op_s)
          OP_LDSW: begin
            o_con_mux       = 1'b1;
            o_con_gpr_shift = 1'b1;
            o_con_gpr_write = 1'b1;
          end
          OP_ADD: begin
            o_con_muxalu    = 1'b1;
            o_con_acc_shift = 1'b1;
            o_con_acc_write = 1'b1;
            o_con_gpr_shift = 1'b1;
          end
          OP_LDA: begin
            o_con_acc_shift = 1'b1;
            o_con_acc_write = 1'b1;
            o_con_gpr_shift = 1'b1;
          end
          OP_ADDG: begin
            o_con_muxalu    = 1'b1;
            o_con_gpr_shift = 1'b1;
            o_con_gpr_write = 1'b1;
            o_con_acc_shift = 1'b1;
          end
          default: begin
            o_con_mux = 1'b0;
          end
        endcase
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ADVANCE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = EXEC;
        end
      end
      ADVANCE: begin
        o_con_pcincr = 1'b1;
        o_instr_done = 1'b1;
        if (i_run) state_d = FETCH;
        else       state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bit_serial_seq.sv
// Self-checking bench for bit_serial_seq: cycle-level control schedules per
// scenario plus a randomized program run through a behavioural datapath.
module tb_bit_serial_seq;

  logic       clk;
  logic       i_rst;
  logic [2:0] i_instr;
  logic       i_run;
  logic       i_start;
  logic [2:0] o_con_mux8;
  logic       o_con_mux, o_con_muxalu, o_con_gpr_shift, o_con_gpr_write;
  logic       o_con_acc_shift, o_con_acc_write, o_con_carry_clr, o_con_pcincr;
  logic       o_rd, o_busy, o_instr_done;
  logic [13:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  bit_serial_seq #(.DATA_W(8)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_instr(i_instr), .i_run(i_run), .i_start(i_start),
    .o_con_mux8(o_con_mux8), .o_con_mux(o_con_mux), .o_con_muxalu(o_con_muxalu),
    .o_con_gpr_shift(o_con_gpr_shift), .o_con_gpr_write(o_con_gpr_write),
    .o_con_acc_shift(o_con_acc_shift), .o_con_acc_write(o_con_acc_write),
    .o_con_carry_clr(o_con_carry_clr), .o_con_pcincr(o_con_pcincr),
    .o_rd(o_rd), .o_busy(o_busy), .o_instr_done(o_instr_done)
  );

  assign obs = {o_con_mux8, o_con_mux, o_con_muxalu, o_con_gpr_shift, o_con_gpr_write,
                o_con_acc_shift, o_con_acc_write, o_con_carry_clr, o_con_pcincr,
                o_rd, o_busy, o_instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Phases: 0 idle, 1 fetch, 2 wait-start, 3 exec bit b, 4 advance.
  function automatic logic [13:0] exp_vec(int ph, logic [1:0] op, logic rd, int b);
    logic [2:0] m8;
    logic mux, malu, gs, gw, as, aw, cc, pc, busy, done;
    m8 = 3'd0; mux = 1'b0; malu = 1'b0; gs = 1'b0; gw = 1'b0;
    as = 1'b0; aw = 1'b0; cc = 1'b0; pc = 1'b0; done = 1'b0;
    busy = (ph != 0);
    if (ph == 1 || ph == 2) cc = 1'b1;
    if (ph == 3) begin
      m8 = 3'(b);
      case (op)
        2'd0: begin mux = 1'b1; gs = 1'b1; gw = 1'b1; end
        2'd1: begin malu = 1'b1; as = 1'b1; aw = 1'b1; gs = 1'b1; end
        2'd2: begin as = 1'b1; aw = 1'b1; gs = 1'b1; end
        default: begin malu = 1'b1; gs = 1'b1; gw = 1'b1; as = 1'b1; end
      endcase
    end
    if (ph == 4) begin pc = 1'b1; done = 1'b1; end
    return {m8, mux, malu, gs, gw, as, aw, cc, pc, rd, busy, done};
  endfunction

  // Behavioural datapath driven by the sequencer controls.
  logic [7:0] dp_gpr [2];
  logic [7:0] dp_acc, dp_sw;
  logic       dp_c;
  logic [7:0] seed_g0, seed_g1, seed_acc;

  always @(negedge clk) begin : dp_model
    logic a, b, s, gin;
    if (i_rst) begin
      dp_gpr[0] <= seed_g0;
      dp_gpr[1] <= seed_g1;
      dp_acc    <= seed_acc;
      dp_c      <= 1'b0;
    end else begin
      a   = dp_gpr[o_rd][0];
      b   = o_con_muxalu & dp_acc[0];
      s   = a ^ b ^ dp_c;
      gin = o_con_mux ? dp_sw[o_con_mux8] : s;
      if (o_con_carry_clr) dp_c <= 1'b0;
      else                 dp_c <= (a & b) | (a & dp_c) | (b & dp_c);
      if (o_con_gpr_shift) dp_gpr[o_rd] <= {(o_con_gpr_write ? gin : a), dp_gpr[o_rd][7:1]};
      if (o_con_acc_shift) dp_acc <= {(o_con_acc_write ? s : dp_acc[0]), dp_acc[7:1]};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_run = 1'b0; i_start = 1'b0;
    repeat (2) step();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    i_rst = 1'b1; i_run = 1'b0; i_start = 1'b0; i_instr = 3'b111;
    for (int i = 0; i < 5; i++) begin
      step();
      e = exp_vec(0, 2'd0, 1'b0, 0);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL reset_hold cyc %0d: got %h expected %h", i, obs, e); end
    end
    i_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL reset_idle cyc %0d: got %h expected %h", i, obs, e); end
    end
    i_instr = 3'b010; i_run = 1'b1;
    step();
    e = exp_vec(1, 2'd0, 1'b0, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_first_fetch: got %h expected %h", obs, e); end
  endtask

  task automatic test_add();
    logic [13:0] e;
    do_reset();
    i_instr = 3'b010; i_run = 1'b1;
    step();
    e = exp_vec(1, 2'd1, 1'b0, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL add_fetch: got %h expected %h", obs, e); end
    for (int b = 0; b < 8; b++) begin
      step();
      e = exp_vec(3, 2'd1, 1'b0, b);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL add_exec bit %0d: got %h expected %h", b, obs, e); end
    end
    step();
    e = exp_vec(4, 2'd1, 1'b0, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL add_advance: got %h expected %h", obs, e); end
    i_run = 1'b0;
    step();
    e = exp_vec(0, 2'd1, 1'b0, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL add_park: got %h expected %h", obs, e); end
  endtask

  task automatic test_ldsw();
    logic [13:0] e;
    bit parked;
    do_reset();
    i_instr = 3'b001; i_run = 1'b1; i_start = 1'b0;
    step();
    e = exp_vec(1, 2'd0, 1'b0, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL ldsw_fetch: got %h expected %h", obs, e); end
    for (int w = 0; w < 5; w++) begin
      step();
      e = exp_vec(2, 2'd0, 1'b1, 0);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL ldsw_wait %0d: got %h expected %h", w, obs, e); end
      if (w == 4) i_start = 1'b1;
    end
    for (int b = 0; b < 8; b++) begin
      step();
      e = exp_vec(3, 2'd0, 1'b1, b);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL ldsw_exec bit %0d: got %h expected %h", b, obs, e); end
    end
    step();
    e = exp_vec(4, 2'd0, 1'b1, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL ldsw_advance: got %h expected %h", obs, e); end
    step();
    e = exp_vec(1, 2'd0, 1'b1, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL ldsw2_fetch: got %h expected %h", obs, e); end
    for (int w = 0; w < 5; w++) begin
      step();
      e = exp_vec(2, 2'd0, 1'b1, 0);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL ldsw2_stall %0d: got %h expected %h", w, obs, e); end
      if (w == 3) i_start = 1'b0;
      if (w == 4) i_start = 1'b1;
    end
    step();
    e = exp_vec(3, 2'd0, 1'b1, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL ldsw2_exec0: got %h expected %h", obs, e); end
    i_run = 1'b0;
    parked = 1'b0;
    for (int c = 0; c < 20 && !parked; c++) begin
      step();
      if (!o_busy) parked = 1'b1;
    end
    n_tests++;
    if (!parked) begin n_fail++; $display("FAIL ldsw2_park: busy=%b expected 0 within 20 cycles", o_busy); end
  endtask

  task automatic test_addg();
    logic [13:0] e;
    do_reset();
    i_instr = 3'b110; i_run = 1'b1;
    step();
    for (int b = 0; b < 8; b++) begin
      step();
      e = exp_vec(3, 2'd3, 1'b0, b);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL addg_exec bit %0d: got %h expected %h", b, obs, e); end
    end
    step();
    e = exp_vec(4, 2'd3, 1'b0, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL addg_advance: got %h expected %h", obs, e); end
    i_run = 1'b0;
    step();
  endtask

  task automatic test_run_drop();
    logic [13:0] e;
    do_reset();
    i_instr = 3'b011; i_run = 1'b1;
    step();
    for (int b = 0; b < 8; b++) begin
      step();
      e = exp_vec(3, 2'd1, 1'b1, b);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL drop_exec bit %0d: got %h expected %h", b, obs, e); end
      if (b == 3) i_run = 1'b0;
    end
    step();
    e = exp_vec(4, 2'd1, 1'b1, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL drop_advance: got %h expected %h", obs, e); end
    for (int i = 0; i < 4; i++) begin
      step();
      e = exp_vec(0, 2'd1, 1'b1, 0);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL drop_idle cyc %0d: got %h expected %h", i, obs, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    do_reset();
    i_instr = 3'b101; i_run = 1'b1;
    step();
    for (int b = 0; b < 5; b++) begin
      step();
      e = exp_vec(3, 2'd2, 1'b1, b);
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL rstmid_exec bit %0d: got %h expected %h", b, obs, e); end
    end
    i_rst = 1'b1; i_run = 1'b0;
    step();
    i_rst = 1'b0;
    e = exp_vec(0, 2'd0, 1'b0, 0);
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL rstmid_clear: got %h expected %h", obs, e); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL rstmid_quiet cyc %0d: got %h expected %h", i, obs, e); end
    end
  endtask

  task automatic test_random_program();
    logic [7:0] rg [2];
    logic [7:0] racc;
    logic [2:0] ins;
    bit done_seen;
    seed_g0 = 8'($urandom); seed_g1 = 8'($urandom); seed_acc = 8'($urandom);
    rg[0] = seed_g0; rg[1] = seed_g1; racc = seed_acc;
    do_reset();
    ins = 3'($urandom_range(0, 7)); dp_sw = 8'($urandom);
    i_instr = ins; i_run = 1'b1;
    for (int k = 0; k < 40; k++) begin
      done_seen = 1'b0;
      for (int c = 0; c < 300 && !done_seen; c++) begin
        step();
        i_start = 1'($urandom_range(0, 1));
        if (o_instr_done) done_seen = 1'b1;
      end
      n_tests++;
      if (!done_seen) begin
        n_fail++;
        $display("FAIL rand_timeout instr %0d: no instr_done within 300 cycles", k);
        return;
      end
      case (ins[2:1])
        2'd0: rg[ins[0]] = dp_sw;
        2'd1: racc = rg[ins[0]] + racc;
        2'd2: racc = rg[ins[0]];
        default: rg[ins[0]] = rg[ins[0]] + racc;
      endcase
      if ({dp_gpr[0], dp_gpr[1], dp_acc} !== {rg[0], rg[1], racc}) begin
        n_fail++;
        $display("FAIL rand_result instr %0d op %b: got g0=%h g1=%h acc=%h expected g0=%h g1=%h acc=%h",
                 k, ins, dp_gpr[0], dp_gpr[1], dp_acc, rg[0], rg[1], racc);
      end
      ins = 3'($urandom_range(0, 7)); dp_sw = 8'($urandom);
      i_instr = ins;
      if ($urandom_range(0, 5) == 0) begin
        i_run = 1'b0;
        step();
        n_tests++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rand_park instr %0d: busy=%b expected 0", k, o_busy); end
        step();
        i_run = 1'b1;
      end
    end
    i_run = 1'b0;
    repeat (12) step();
  endtask

  initial begin
    i_rst = 1'b1; i_run = 1'b0; i_start = 1'b0; i_instr = 3'b000;
    dp_sw = 8'h00; seed_g0 = 8'h00; seed_g1 = 8'h00; seed_acc = 8'h00;
    test_reset();
    test_add();
    test_ldsw();
    test_addg();
    test_run_drop();
    test_reset_mid();
    test_random_program();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
